// File: rtl/kdb_pkg.sv
// Shared types and constants for the PS/2 keyboard frame controller.
package kdb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } kdb_state_e;

  localparam int   KDB_FRAME_BITS = 11;
  localparam logic KDB_START_BIT  = 1'b0;
  localparam logic KDB_STOP_BIT   = 1'b1;

  function automatic logic kdb_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/kdb_fifo.sv
// Synchronous circular FIFO; DEPTH must be a power of two.
// Push while full is dropped; push and pop together keep the count.
module kdb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/kdb_frame_ctrl.sv
// PS/2 device-side frame controller: buffers scancodes, emits 11-bit frames.
// KDB_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise one holding register.
module kdb_frame_ctrl
  import kdb_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_dat,
  output logic       busy
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int NI = (KDB_FRAME_BITS > GAP_BITS) ? KDB_FRAME_BITS : GAP_BITS;
  localparam int IW = $clog2(NI);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
  localparam logic [IW-1:0] BIT_LAST = IW'(KDB_FRAME_BITS - 1);
  localparam logic [IW-1:0] GAP_LAST = IW'(GAP_BITS - 1);

  kdb_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KDB_FRAME_BITS-1:0] sh_q, sh_d;
  logic clk_q, clk_d;
  logic dat_q, dat_d;

  logic       push, pop;
  logic       buf_empty, buf_any;
  logic [7:0] buf_head;

  assign push = in_valid && in_ready;

`ifdef KDB_FIFO_EN
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

  kdb_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (push),
    .data_i (in_data),
    .pop_i  (pop),
    .data_o (buf_head),
    .full_o (fifo_full),
    .empty_o(buf_empty),
    .count_o(fifo_cnt)
  );

  assign in_ready = !fifo_full;
  assign buf_any  = |fifo_cnt;
`else
  logic       hold_v_q, hold_v_d;
  logic [7:0] hold_q;

  assign in_ready  = !hold_v_q;
  assign buf_empty = !hold_v_q;
  assign buf_any   = hold_v_q;
  assign buf_head  = hold_q;

  // push needs an empty register and pop a full one, so they never overlap
  always_comb begin
    hold_v_d = hold_v_q;
    if (push)     hold_v_d = 1'b1;
    else if (pop) hold_v_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      if (push) hold_q <= in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          sh_d    = {KDB_STOP_BIT, kdb_odd_parity(buf_head),
                     buf_head, KDB_START_BIT};
          phase_d = '0;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        phase_d = phase_q + PW'(1);
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sh_d    = {1'b1, sh_q[KDB_FRAME_BITS-1:1]};
          if (idx_q == BIT_LAST) begin
            idx_d   = '0;
            state_d = ST_GAP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_GAP: begin
        phase_d = phase_q + PW'(1);
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (idx_q == GAP_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs register the next-state view so the wire tracks the counters
  always_comb begin
    clk_d = !((state_d == ST_SHIFT) && (phase_d >= PH_HALF));
    dat_d = (state_d == ST_SHIFT) ? sh_d[0] : 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      sh_q    <= '1;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
    end
  end

  assign ps2_clk = clk_q;
  assign ps2_dat = dat_q;
  assign busy    = (state_q != ST_IDLE) || buf_any;

endmodule

// File: tb/tb_kdb_frame_ctrl.sv
// Bench for kdb_frame_ctrl: frame-timeline model plus host-side sampler.
// Expectations follow KDB_FIFO_EN as the design build does.
module tb_kdb_frame_ctrl;

  localparam int CLK_DIV    = 8;
  localparam int GAP_BITS   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CYC  = 11 * CLK_DIV;
  localparam int GAP_CYC    = GAP_BITS * CLK_DIV;
  localparam int SPACING    = FRAME_CYC + GAP_CYC + 1;
`ifdef KDB_FIFO_EN
  localparam int CAP        = FIFO_DEPTH;
  localparam int HOLD_ACC   = 5;
  localparam int RDY_AFTER1 = 1;
  localparam int D23        = 1;
`else
  localparam int CAP        = 1;
  localparam int HOLD_ACC   = 2;
  localparam int RDY_AFTER1 = 0;
  localparam int D23        = SPACING;
`endif

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       busy;

  kdb_frame_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model: pending bytes, and time since the current frame started
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;

  // host-side sampler
  logic        prev_clk = 1'b1;
  logic [10:0] cap_w = '0;
  int          cap_n = 0;
  int          falls = 0;
  logic [10:0] frames[$];
  int          fall_cyc[$];
  int          last_low = 0;
  int          busy_run = 0;
  int          busy_last = 0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  function automatic logic [10:0] frame_word(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic tick();
    bit do_pop, do_push;
    logic e_clk, e_dat;
    logic [10:0] w;
    @(posedge clock);
    cyc++;
    if (reset) begin
      mq.delete();
      m_act = 0;
      m_t   = 0;
      cap_n = 0;
    end else begin
      do_pop  = !m_act && (mq.size() > 0);
      do_push = in_valid && (mq.size() < CAP);
      if (m_act) begin
        m_t++;
        if (m_t == FRAME_CYC + GAP_CYC) m_act = 0;
      end
      if (do_pop) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t   = 0;
      end
      if (do_push) mq.push_back(in_data);
    end
    e_clk = 1'b1;
    e_dat = 1'b1;
    if (m_act && m_t < FRAME_CYC) begin
      w     = frame_word(m_cur);
      e_clk = (m_t % CLK_DIV) < (CLK_DIV / 2);
      e_dat = w[m_t / CLK_DIV];
    end
    @(negedge clock);
    check("ps2_clk", ps2_clk, e_clk);
    check("ps2_dat", ps2_dat, e_dat);
    check("in_ready", in_ready, mq.size() < CAP);
    check("busy", busy, m_act || mq.size() > 0);
    if (prev_clk && !ps2_clk) begin
      if (cap_n == 0) fall_cyc.push_back(cyc);
      cap_w = {ps2_dat, cap_w[10:1]};
      cap_n++;
      falls++;
      if (cap_n == 11) begin
        frames.push_back(cap_w);
        cap_n = 0;
      end
    end
    prev_clk = ps2_clk;
    if (!ps2_clk) last_low = cyc;
    if (busy) busy_run++;
    else begin
      if (busy_run > 0) busy_last = busy_run;
      busy_run = 0;
    end
  endtask

  task automatic push(input logic [7:0] b, output int at);
    int n;
    at = -1;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (at < 0 && n < 400) begin
      if (in_ready) at = cyc + 1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("push_accepted", at >= 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy !== 1'b0 || m_act || mq.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check("idle_reached", n < bound, 1);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, t0, f0, nfr, nfc;
    int acc;
    logic [7:0] exp_hold[$];
    logic [7:0] rb[$];

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    repeat (3) begin
      tick();
      check("rst_clk", ps2_clk, 1);
      check("rst_dat", ps2_dat, 1);
      check("rst_rdy", in_ready, 1);
      check("rst_busy", busy, 0);
    end
    reset = 1'b0;
    repeat (100) tick();
    check("idle_falls", falls, 0);

    // single frame 0x1C
    nfr = frames.size();
    nfc = fall_cyc.size();
    f0  = falls;
    push(8'h1C, a1);
    tick();
    check("start_dat", ps2_dat, 0);
    check("start_clk", ps2_clk, 1);
    check("entry_edge", cyc, a1 + 1);
    t0 = cyc;
    wait_idle(400);
    check("frame_len", last_low - t0 + 1, FRAME_CYC);
    check("frame_falls", falls - f0, 11);
    check("frame_cnt_1c", frames.size() - nfr, 1);
    if (frames.size() > nfr) check("frame_1c", frames[nfr], 11'h438);
    if (fall_cyc.size() > nfc)
      check("first_fall", fall_cyc[nfc] - t0, CLK_DIV / 2);

    // back-to-back 0xF0, 0x1C
    nfr = frames.size();
    nfc = fall_cyc.size();
    push(8'hF0, a1);
    push(8'h1C, a2);
    wait_idle(600);
    check("frame_cnt_b2b", frames.size() - nfr, 2);
    if (frames.size() > nfr + 1) begin
      check("frame_f0", frames[nfr], 11'h7E0);
      check("frame_1c_b", frames[nfr+1], 11'h438);
    end
    if (fall_cyc.size() > nfc + 1)
      check("spacing", fall_cyc[nfc+1] - fall_cyc[nfc], SPACING);
    check("busy_run", busy_last, 210);

    // in_valid held for 8 cycles
`ifdef KDB_FIFO_EN
    exp_hold = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
`else
    exp_hold = '{8'h10, 8'h12};
`endif
    nfr = frames.size();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("hold_acc", acc, HOLD_ACC);
    wait_idle(2000);
    check("hold_frames", frames.size() - nfr, exp_hold.size());
    for (int j = 0; j < exp_hold.size(); j++)
      if (frames.size() > nfr + j)
        check("hold_order", frames[nfr+j], frame_word(exp_hold[j]));

    // reset during bit 5 with bytes queued
    push(8'h21, a1);
    push(8'h22, a2);
`ifdef KDB_FIFO_EN
    push(8'h23, a3);
`endif
    while (cyc < a1 + 1 + 5 * CLK_DIV + 2) tick();
    check("mid_bit5_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_clk", ps2_clk, 1);
    check("mrst_dat", ps2_dat, 1);
    check("mrst_busy", busy, 0);
    check("mrst_rdy", in_ready, 1);
    nfr = frames.size();
    f0  = falls;
    repeat (300) tick();
    check("mrst_no_frames", frames.size() - nfr, 0);
    check("mrst_no_falls", falls - f0, 0);
    push(8'h5A, a1);
    wait_idle(400);
    check("post_rst_cnt", frames.size() - nfr, 1);
    if (frames.size() > nfr) check("frame_5a", frames[nfr], 11'h6B4);

    // handshake spacing
    nfr = frames.size();
    rb  = '{8'h31, 8'h32, 8'h33};
    push(rb[0], a1);
    check("rdy_after_push", in_ready, RDY_AFTER1);
    tick();
    check("rdy_after_load", in_ready, 1);
    push(rb[1], a2);
    push(rb[2], a3);
    check("hs_d12", a2 - a1, 2);
    check("hs_d23", a3 - a2, D23);
    wait_idle(800);
    check("hs_frames", frames.size() - nfr, 3);
    for (int j = 0; j < 3; j++)
      if (frames.size() > nfr + j)
        check("hs_order", frames[nfr+j], frame_word(rb[j]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
